nec_ir_state_decoder: RTL and testbench
=======================================

Name: nec_ir_state_decoder

Overview:
Decodes NEC-protocol infrared frames from a demodulated IR receiver pin into the 3-bit motion command consumed by the JSON/UART command transmitter (state_control). Frames are validated for timing, address and inverted-byte integrity. Repeat codes extend the current command. A hold timer forces STOP if the remote goes silent.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; sets the 1 us prescaler (CLK_FREQ_HZ/1_000_000 cycles per tick).
ADDR, 8'h00, accepted NEC address byte.
HOLD_MS, 200, ms without a valid frame or repeat before forcing STOP; 0 disables the timeout.
CMD_STOP / CMD_LEFT / CMD_RIGHT / CMD_FWD_SLOW / CMD_FWD_MED / CMD_FWD_FAST / CMD_REVERSE, 8'h1C / 8'h08 / 8'h5A / 8'h45 / 8'h18 / 8'h47 / 8'h52, NEC command byte mapped to each state.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ir_in  in  1  demodulated IR; idle high, mark = low; asynchronous
state_control  out  3  000 STOP, 001 LEFT, 010 RIGHT, 011 FWD_SLOW, 100 FWD_MED, 101 FWD_FAST, 110 REVERSE
cmd_valid  out  1  1-cycle pulse: accepted full frame
repeat_valid  out  1  1-cycle pulse: accepted repeat code
cmd_code  out  8  last accepted command byte
frame_error  out  1  1-cycle pulse: timing or integrity failure

Behaviour:
- Reset values: state_control=000, cmd_code=0, all pulses 0, FSM=IDLE, counters 0.
- Synchronisation: ir_in passes through a 2-FF synchroniser, then a registered edge detect. Edges are seen 3 clk after the pin changes.
- Width counter: counts 1 us ticks, 16 bits, saturates at 16'hFFFF, clears on every edge. The width of each level is judged at the edge that ends it.
- Windows (inclusive, us): leader mark 8000-10000; frame space 4000-5000; repeat space 2000-2500; bit mark 400-750; 0-space 400-750; 1-space 1400-1900.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK, TRAIL.
- IDLE: on a falling edge -> LEAD_MARK.
- LEAD_MARK: on a rising edge, width in window -> LEAD_SPACE.
- LEAD_SPACE: on a falling edge, frame space -> BIT_MARK with bit count=0; repeat space -> RPT_MARK.
- BIT_MARK: on a rising edge, mark in window -> BIT_SPACE.
- BIT_SPACE: on a falling edge, shift in the bit LSB-first into a 32-bit register and increment the count. After bit 32 -> TRAIL, otherwise -> BIT_MARK.
- RPT_MARK: on a rising edge, mark in window -> repeat check, then IDLE.
- TRAIL: waits for a rising edge (end of stop mark), then IDLE. The stop-mark width is not checked.
- Abort: any level out of window at its ending edge, or the running width exceeding the state's max window before an edge, pulses frame_error 1 cycle and goes to IDLE if the line is high. If the line is low, it goes to a wait-for-high path (TRAIL). IDLE never times out.
- Frame check, in the cycle after bit 32 is shifted: byte0=addr, byte1=~addr, byte2=cmd, byte3=~cmd.
  - Either inverse mismatch -> frame_error.
  - addr!=ADDR -> silently ignored (no pulse).
  - Otherwise pulse cmd_valid, load cmd_code and reload the hold timer.
  - If cmd matches a mapped code, state_control updates in the same cycle as cmd_valid. Unmapped codes leave state_control unchanged.
- Repeat: accepted only while the hold timer is running (nonzero) and at least one frame has been accepted since reset. An accepted repeat pulses repeat_valid and reloads the hold timer. Otherwise the repeat is ignored with no error.
- Hold timer: ms counter driven from the us tick. When it reaches 0 from nonzero, state_control <= 000 in that cycle. If a frame commit coincides with expiry, the commit wins. HOLD_MS=0: no timeout, and repeats are always accepted after the first frame.
- Reset mid-frame: all state is cleared immediately; the partial frame is discarded with no pulses.
- At most one of cmd_valid / repeat_valid / frame_error is high in any cycle.

Test Plan:
- Bench uses CLK_FREQ_HZ=1_000_000 for speed.
- Valid frame addr 00/FF, cmd 18/E7 -> one cmd_valid pulse, cmd_code=8'h18, state_control=100. No frame_error.
- Frame cmd 08, then repeat codes every 108 ms for 500 ms -> state_control stays 001 with one repeat_valid per repeat. 200 ms after the last repeat, state_control=000.
- Frame cmd 52 with byte3=8'hAE (wrong inverse) -> frame_error pulse; state_control and cmd_code unchanged.
- Leader mark of 7000 us, then a valid-looking frame -> frame_error at the leader rising edge; FSM returns to IDLE; no cmd_valid.
- Frame with addr 8'h01/FE -> no pulses, outputs unchanged. Repeat code sent after reset with no prior frame -> ignored.
- rst asserted after bit 17 of a frame, released, then a valid cmd 5A frame -> no output from the first frame; second frame gives state_control=010.

Source files
------------

// File: rtl/nec_ir_state_decoder_if.sv
// nec_ir_state_decoder_if: IR pin input and decoded motion-command outputs
interface nec_ir_state_decoder_if;
    logic       ir_in;
    logic [2:0] state_control;
    logic       cmd_valid;
    logic       repeat_valid;
    logic [7:0] cmd_code;
    logic       frame_error;
    modport master (output ir_in, input state_control, cmd_valid, repeat_valid, cmd_code, frame_error);
    modport slave (input ir_in, output state_control, cmd_valid, repeat_valid, cmd_code, frame_error);
endinterface

// File: rtl/nec_ir_state_decoder.sv
// nec_ir_state_decoder: validates NEC IR frames/repeats and maps them to a held motion command
module nec_ir_state_decoder #(
    parameter int         CLK_FREQ_HZ  = 50_000_000,
    parameter logic [7:0] ADDR         = 8'h00,
    parameter int         HOLD_MS      = 200,
    parameter logic [7:0] CMD_STOP     = 8'h1C,
    parameter logic [7:0] CMD_LEFT     = 8'h08,
    parameter logic [7:0] CMD_RIGHT    = 8'h5A,
    parameter logic [7:0] CMD_FWD_SLOW = 8'h45,
    parameter logic [7:0] CMD_FWD_MED  = 8'h18,
    parameter logic [7:0] CMD_FWD_FAST = 8'h47,
    parameter logic [7:0] CMD_REVERSE  = 8'h52
) (
    input logic                   clk,
    input logic                   rst,
    nec_ir_state_decoder_if.slave bus
);
    localparam logic [15:0] DIV = 16'(CLK_FREQ_HZ / 1_000_000);
    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK, TRAIL} fsm_e;
    fsm_e        fsm_q, fsm_d;
    logic [1:0]  sync_q;
    logic        line_q, rise_q, fall_q, tick, ms_tick;
    logic [15:0] div_q, width_q, hold_q, hold_d, max_w;
    logic [9:0]  us_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cmd, code_q, code_d;
    logic [2:0]  st_q, st_d, map_st;
    logic        check_q, check_d, got_q, got_d, reload, abort, map_ok, is_one, is_zero, mark_ok;
    logic        valid_q, valid_d, rpt_q, rpt_d, err_q, err_d;

    function automatic logic win(input logic [15:0] w, input logic [15:0] lo, input logic [15:0] hi);
        return w >= lo && w <= hi;
    endfunction

    assign tick    = div_q == DIV - 16'd1;
    assign ms_tick = tick && us_q == 10'd999;
    assign is_one  = win(width_q, 16'd1400, 16'd1900);
    assign is_zero = win(width_q, 16'd400, 16'd750);
    assign mark_ok = win(width_q, 16'd400, 16'd750);
    assign max_w   = fsm_q == LEAD_MARK ? 16'd10000 : fsm_q == LEAD_SPACE ? 16'd5000 :
                     fsm_q == BIT_SPACE ? 16'd1900 : (fsm_q == BIT_MARK || fsm_q == RPT_MARK) ? 16'd750 : 16'hFFFF;
    assign cmd     = data_q[23:16];
    assign map_st  = cmd == CMD_LEFT ? 3'd1 : cmd == CMD_RIGHT ? 3'd2 : cmd == CMD_FWD_SLOW ? 3'd3 :
                     cmd == CMD_FWD_MED ? 3'd4 : cmd == CMD_FWD_FAST ? 3'd5 : cmd == CMD_REVERSE ? 3'd6 : 3'd0;
    assign map_ok  = cmd inside {CMD_STOP, CMD_LEFT, CMD_RIGHT, CMD_FWD_SLOW, CMD_FWD_MED, CMD_FWD_FAST, CMD_REVERSE};

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        check_d = 1'b0;
        got_d   = got_q;
        code_d  = code_q;
        st_d    = st_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        rpt_d   = 1'b0;
        err_d   = 1'b0;
        reload  = 1'b0;
        abort   = 1'b0;
        case (fsm_q)
            IDLE:       if (fall_q) fsm_d = LEAD_MARK;
            LEAD_MARK:  if (rise_q) begin
                if (win(width_q, 16'd8000, 16'd10000)) fsm_d = LEAD_SPACE;
                else abort = 1'b1;
            end
            LEAD_SPACE: if (fall_q) begin
                if (win(width_q, 16'd4000, 16'd5000)) begin
                    fsm_d = BIT_MARK;
                    cnt_d = 6'd0;
                end else if (win(width_q, 16'd2000, 16'd2500)) fsm_d = RPT_MARK;
                else abort = 1'b1;
            end
            BIT_MARK:   if (rise_q) begin
                if (mark_ok) fsm_d = BIT_SPACE;
                else abort = 1'b1;
            end
            BIT_SPACE:  if (fall_q) begin
                if (is_one || is_zero) begin
                    data_d  = {is_one, data_q[31:1]};
                    cnt_d   = cnt_q + 6'd1;
                    check_d = cnt_q == 6'd31;
                    fsm_d   = cnt_q == 6'd31 ? TRAIL : BIT_MARK;
                end else abort = 1'b1;
            end
            RPT_MARK:   if (rise_q) begin
                if (mark_ok) begin
                    fsm_d = IDLE;
                    if (got_q && (HOLD_MS == 0 || hold_q != 16'd0)) begin
                        rpt_d  = 1'b1;
                        reload = 1'b1;
                    end
                end else abort = 1'b1;
            end
            TRAIL:      if (rise_q) fsm_d = IDLE;
            default:    fsm_d = IDLE;
        endcase
        if (!rise_q && !fall_q && width_q > max_w) abort = 1'b1;
        if (abort) begin
            err_d = 1'b1;
            fsm_d = line_q ? IDLE : TRAIL;
        end
        if (ms_tick && hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
            if (hold_q == 16'd1) st_d = 3'd0;
        end
        // Commit is evaluated after expiry so a coinciding frame wins
        if (check_q) begin
            if (data_q[15:8] != ~data_q[7:0] || data_q[31:24] != ~data_q[23:16]) err_d = 1'b1;
            else if (data_q[7:0] == ADDR) begin
                valid_d = 1'b1;
                code_d  = cmd;
                got_d   = 1'b1;
                reload  = 1'b1;
                st_d    = map_ok ? map_st : st_q;
            end
        end
        if (reload) hold_d = 16'(HOLD_MS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            line_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            div_q   <= 16'd0;
            width_q <= 16'd0;
            us_q    <= 10'd0;
            hold_q  <= 16'd0;
            fsm_q   <= IDLE;
            cnt_q   <= 6'd0;
            data_q  <= 32'd0;
            check_q <= 1'b0;
            got_q   <= 1'b0;
            code_q  <= 8'd0;
            st_q    <= 3'd0;
            valid_q <= 1'b0;
            rpt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.ir_in};
            line_q  <= sync_q[1];
            rise_q  <= ~line_q & sync_q[1];
            fall_q  <= line_q & ~sync_q[1];
            div_q   <= tick ? 16'd0 : div_q + 16'd1;
            width_q <= (rise_q || fall_q) ? 16'd0 : (tick && width_q != 16'hFFFF) ? width_q + 16'd1 : width_q;
            us_q    <= reload ? 10'd0 : tick ? (us_q == 10'd999 ? 10'd0 : us_q + 10'd1) : us_q;
            hold_q  <= hold_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            check_q <= check_d;
            got_q   <= got_d;
            code_q  <= code_d;
            st_q    <= st_d;
            valid_q <= valid_d;
            rpt_q   <= rpt_d;
            err_q   <= err_d;
        end
    end

    assign bus.state_control = st_q;
    assign bus.cmd_code      = code_q;
    assign bus.cmd_valid     = valid_q;
    assign bus.repeat_valid  = rpt_q;
    assign bus.frame_error   = err_q;
endmodule

// File: tb/tb_nec_ir_state_decoder.sv
// tb_nec_ir_state_decoder: directed NEC frame, repeat, hold and error scenarios at a 1 us clock
module tb_nec_ir_state_decoder;
    localparam int HOLD = 80;
    localparam int LEAD = 8100, FSP = 4100, RSP = 2100, BM = 450, ZS = 450, OS = 1450, GAP = 1000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    int n_valid = 0, n_rpt = 0, n_err = 0, n_multi = 0;
    logic [2:0] st_at_valid = 3'd7;

    nec_ir_state_decoder_if bus();
    nec_ir_state_decoder #(.CLK_FREQ_HZ(1_000_000), .HOLD_MS(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmd_valid) begin
            n_valid++;
            st_at_valid = bus.state_control;
        end
        if (bus.repeat_valid) n_rpt++;
        if (bus.frame_error) n_err++;
        if (int'(bus.cmd_valid) + int'(bus.repeat_valid) + int'(bus.frame_error) > 1) n_multi++;
    end

    initial begin
        repeat (800_000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic level(input logic v, input int us);
        bus.ir_in = v;
        repeat (us) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            level(1'b0, BM);
            level(1'b1, w[i] ? OS : ZS);
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        level(1'b0, LEAD);
        level(1'b1, FSP);
        send_bits(w, 32);
        level(1'b0, BM);
        level(1'b1, GAP);
    endtask

    task automatic send_repeat();
        level(1'b0, LEAD);
        level(1'b1, RSP);
        level(1'b0, BM);
        level(1'b1, GAP);
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_rpt = 0;
        n_err = 0;
    endtask

    task automatic test_reset();
        bus.ir_in = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.state_control !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_control); end
        checks++; if (bus.cmd_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %0h expected 00", bus.cmd_code); end
        checks++; if (bus.cmd_valid !== 1'b0 || bus.repeat_valid !== 1'b0 || bus.frame_error !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got %b%b%b expected 000", bus.cmd_valid, bus.repeat_valid, bus.frame_error); end
    endtask

    task automatic test_repeat_no_frame();
        clear_counts();
        send_repeat();
        checks++; if (n_rpt !== 0) begin errors++; $display("FAIL rpt_noframe_count: got %0d expected 0", n_rpt); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL rpt_noframe_err: got %0d expected 0", n_err); end
        checks++; if (bus.state_control !== 3'd0) begin errors++; $display("FAIL rpt_noframe_state: got %0d expected 0", bus.state_control); end
    endtask

    task automatic test_wrong_addr();
        clear_counts();
        send_frame({8'hE7, 8'h18, 8'hFE, 8'h01});
        send_repeat();
        checks++; if (n_valid !== 0 || n_err !== 0 || n_rpt !== 0) begin
            errors++; $display("FAIL addr_pulses: got valid=%0d err=%0d rpt=%0d expected 0/0/0", n_valid, n_err, n_rpt); end
        checks++; if (bus.state_control !== 3'd0) begin errors++; $display("FAIL addr_state: got %0d expected 0", bus.state_control); end
        checks++; if (bus.cmd_code !== 8'h00) begin errors++; $display("FAIL addr_code: got %0h expected 00", bus.cmd_code); end
    endtask

    task automatic test_valid_frame();
        clear_counts();
        send_frame({8'hE7, 8'h18, 8'hFF, 8'h00});
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL valid_count: got %0d expected 1", n_valid); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL valid_err: got %0d expected 0", n_err); end
        checks++; if (bus.cmd_code !== 8'h18) begin errors++; $display("FAIL valid_code: got %0h expected 18", bus.cmd_code); end
        checks++; if (bus.state_control !== 3'd4) begin errors++; $display("FAIL valid_state: got %0d expected 4", bus.state_control); end
        checks++; if (st_at_valid !== 3'd4) begin errors++; $display("FAIL valid_state_with_pulse: got %0d expected 4", st_at_valid); end
    endtask

    task automatic test_bad_inverse();
        clear_counts();
        send_frame({8'hAE, 8'h52, 8'hFF, 8'h00});
        checks++; if (n_err !== 1) begin errors++; $display("FAIL inv_err: got %0d expected 1", n_err); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL inv_valid: got %0d expected 0", n_valid); end
        checks++; if (bus.state_control !== 3'd4) begin errors++; $display("FAIL inv_state: got %0d expected 4", bus.state_control); end
        checks++; if (bus.cmd_code !== 8'h18) begin errors++; $display("FAIL inv_code: got %0h expected 18", bus.cmd_code); end
    endtask

    task automatic test_repeat_hold();
        clear_counts();
        send_frame({8'hF7, 8'h08, 8'hFF, 8'h00});
        checks++; if (bus.state_control !== 3'd1) begin errors++; $display("FAIL hold_frame_state: got %0d expected 1", bus.state_control); end
        for (int r = 0; r < 4; r++) begin
            level(1'b1, 2000);
            send_repeat();
        end
        checks++; if (n_rpt !== 4) begin errors++; $display("FAIL hold_rpt_count: got %0d expected 4", n_rpt); end
        checks++; if (n_err !== 0 || n_valid !== 1) begin errors++; $display("FAIL hold_other_pulses: got err=%0d valid=%0d expected 0/1", n_err, n_valid); end
        checks++; if (bus.state_control !== 3'd1) begin errors++; $display("FAIL hold_rpt_state: got %0d expected 1", bus.state_control); end
        level(1'b1, (HOLD - 5) * 1000);
        checks++; if (bus.state_control !== 3'd1) begin errors++; $display("FAIL hold_before_expiry: got %0d expected 1", bus.state_control); end
        level(1'b1, 10_000);
        checks++; if (bus.state_control !== 3'd0) begin errors++; $display("FAIL hold_after_expiry: got %0d expected 0", bus.state_control); end
        send_repeat();
        checks++; if (n_rpt !== 4) begin errors++; $display("FAIL hold_late_rpt: got %0d expected 4", n_rpt); end
        checks++; if (bus.state_control !== 3'd0 || bus.cmd_code !== 8'h08) begin
            errors++; $display("FAIL hold_late_outputs: got state=%0d code=%0h expected 0/08", bus.state_control, bus.cmd_code); end
    endtask

    task automatic test_short_leader();
        clear_counts();
        level(1'b0, 7000);
        level(1'b1, 20);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL short_lead_err: got %0d expected 1", n_err); end
        checks++; if (3'(dut.fsm_q) !== 3'd0) begin errors++; $display("FAIL short_lead_fsm: got %0d expected 0", 3'(dut.fsm_q)); end
        level(1'b1, FSP - 20);
        send_bits({8'hE7, 8'h18, 8'hFF, 8'h00}, 8);
        level(1'b0, BM);
        level(1'b1, GAP);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL short_lead_valid: got %0d expected 0", n_valid); end
        checks++; if (bus.state_control !== 3'd0 || bus.cmd_code !== 8'h08) begin
            errors++; $display("FAIL short_lead_outputs: got state=%0d code=%0h expected 0/08", bus.state_control, bus.cmd_code); end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        level(1'b0, LEAD);
        level(1'b1, FSP);
        send_bits({8'hA5, 8'h5A, 8'hFF, 8'h00}, 17);
        level(1'b0, 200);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        bus.ir_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        level(1'b1, GAP);
        checks++; if (n_valid !== 0 || n_err !== 0 || n_rpt !== 0) begin
            errors++; $display("FAIL midrst_pulses: got valid=%0d err=%0d rpt=%0d expected 0/0/0", n_valid, n_err, n_rpt); end
        checks++; if (bus.cmd_code !== 8'h00) begin errors++; $display("FAIL midrst_code: got %0h expected 00", bus.cmd_code); end
        send_frame({8'hA5, 8'h5A, 8'hFF, 8'h00});
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL midrst_valid: got %0d expected 1", n_valid); end
        checks++; if (bus.state_control !== 3'd2) begin errors++; $display("FAIL midrst_state: got %0d expected 2", bus.state_control); end
        checks++; if (bus.cmd_code !== 8'h5A) begin errors++; $display("FAIL midrst_code2: got %0h expected 5a", bus.cmd_code); end
    endtask

    initial begin
        bus.ir_in = 1'b1;
        test_reset();
        test_repeat_no_frame();
        test_wrong_addr();
        test_valid_frame();
        test_bad_inverse();
        test_repeat_hold();
        test_short_leader();
        test_reset_mid_frame();
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", n_multi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
